// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin picker.
// State encoding is fixed so the read-side scheduler can reuse the same values.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, wrapping.
// Rotate so rr_ptr lands on bit 0, priority-encode, then add rr_ptr back modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int RW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [RW-1:0]   rr_ptr,
    output logic [RW-1:0]   owner,
    output logic            valid
);

    logic [NREQ-1:0] rot;
    logic [RW:0]     ofs;
    logic [RW:0]     sum;

    always_comb begin
        rot   = (req >> rr_ptr) | (req << (NREQ - int'(rr_ptr)));
        ofs   = '0;
        valid = 1'b0;
        // Walk downward so the lowest set bit wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                ofs   = (RW+1)'(k);
                valid = 1'b1;
            end
        end
        sum = {1'b0, rr_ptr} + ofs;
        if (sum >= (RW+1)'(NREQ)) sum = sum - (RW+1)'(NREQ);
        owner = sum[RW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter sharing the dual-clock FIFO write port among NREQ producers.
// A burst starts only when almost-full is clear; a GAP cycle separates owners.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int DW    = 8,
    parameter int NREQ  = 4,
    parameter int RW    = 2,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    ack,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    input  logic               fifo_full,
    input  logic               fifo_full_n,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din
);

    localparam int CW = (BURST == 1) ? 1 : clog2(BURST);

    state_t          state, state_nx;
    logic [NREQ-1:0] gnt_nx;
    logic [RW-1:0]   owner, owner_nx;
    logic [RW-1:0]   rr_ptr, rr_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [RW-1:0]   pick;
    logic            pick_vld;
    logic            owner_req;
    logic            start;

    rr_pick #(.NREQ(NREQ), .RW(RW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .owner  (pick),
        .valid  (pick_vld)
    );

    always_comb begin
        owner_req = 1'b0;
        fifo_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == RW'(i)) begin
                owner_req = req[i];
                fifo_din  = din[i*DW +: DW];
            end
        end
    end

    // Almost-full is only looked at here; once started, BURST <= n guarantees room.
    assign start = pick_vld && !fifo_full && !fifo_full_n;

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        owner_nx = owner;
        rr_nx    = rr_ptr;
        cnt_nx   = cnt;
        fifo_we  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    owner_nx = pick;
                    gnt_nx   = NREQ'(1) << pick;
                    cnt_nx   = '0;
                    state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                fifo_we = owner_req && !fifo_full;
                if (fifo_we) cnt_nx = cnt + CW'(1);
                if ((fifo_we && cnt == CW'(BURST - 1)) || !owner_req || fifo_full) begin
                    gnt_nx   = '0;
                    state_nx = ST_GAP;
                end
            end
            ST_GAP: begin
                rr_nx    = (owner == RW'(NREQ - 1)) ? '0 : owner + RW'(1);
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (clr) begin
            state_nx = ST_IDLE;
            gnt_nx   = '0;
            rr_nx    = '0;
            cnt_nx   = '0;
            fifo_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            gnt    <= gnt_nx;
            owner  <= owner_nx;
            rr_ptr <= rr_nx;
            cnt    <= cnt_nx;
        end
    end

    assign ack  = gnt & {NREQ{fifo_we}};
    assign busy = (state != ST_IDLE);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            assert (!(fifo_we && fifo_full)) else $error("fifo_we asserted while fifo_full");
            assert ($onehot0(ack)) else $error("ack is not one-hot-or-zero");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: per-cycle vector table plus hand sequences, with a write
// scoreboard fed by the expected producer data and drained on every observed write.
module tb_fifo_wr_arb;

    logic        clk, rst, clr;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  ack, gnt;
    logic        busy, fifo_full, fifo_full_n, fifo_we;
    logic [7:0]  fifo_din;

    fifo_wr_arb #(.DW(8), .NREQ(4), .RW(2), .BURST(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .req(req), .din(din), .ack(ack), .gnt(gnt),
        .busy(busy), .fifo_full(fifo_full), .fifo_full_n(fifo_full_n),
        .fifo_we(fifo_we), .fifo_din(fifo_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int         src;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        bit         rf;
        int         psrc;
        int         pn;
        logic [3:0] req;
        logic       full;
        logic       fn;
        logic       we;
        logic [3:0] gnt;
        logic       busy;
    } vec_t;

    exp_t       sb[$];
    vec_t       tv[$];
    logic [7:0] data[4];
    logic [3:0] acked;
    int         n_chk = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic drive_din();
        for (int i = 0; i < 4; i++) din[i*8 +: 8] = data[i];
    endtask

    task automatic push_n(input int src, input int n);
        for (int k = 0; k < n; k++) sb.push_back('{src, data[src] + 8'(k)});
    endtask

    task automatic sample();
        exp_t       e;
        logic [3:0] oh;
        @(negedge clk);
        acked = ack;
        if (fifo_we) begin
            chk("we_while_full", 32'(fifo_full), 32'd0);
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: write of %0h with ack %b, none expected", fifo_din, ack);
            end else begin
                e  = sb.pop_front();
                oh = 4'b0001 << e.src;
                chk("sb_data", 32'(fifo_din), 32'(e.d));
                chk("sb_ack", 32'(ack), 32'(oh));
            end
        end
    endtask

    task automatic adv();
        sample();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acked[i]) data[i] = data[i] + 8'd1;
        drive_din();
    endtask

    task automatic do_reset();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        rst = 1'b0; clr = 1'b0; req = '0; fifo_full = 1'b0; fifo_full_n = 1'b0;
        for (int i = 0; i < 4; i++) data[i] = 8'(16 * (i + 1));
        drive_din();
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_we", 32'(fifo_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b1;
        acked = '0;
    endtask

    task automatic addv(input bit rf, input int psrc, input int pn, input logic [3:0] r,
                        input logic f, input logic fn, input logic we, input logic [3:0] g,
                        input logic b);
        tv.push_back('{rf, psrc, pn, r, f, fn, we, g, b});
    endtask

    initial begin
        logic [7:0] nd[4];
        logic [3:0] oh;
        int         o;
        rst = 1'b0; clr = 1'b0; req = '0; fifo_full = 1'b0; fifo_full_n = 1'b0; din = '0;
        acked = '0;

        // Single requester: 4-word bursts, two idle write-port cycles between them.
        addv(1, 0, 7, 4'b0001, 0, 0, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 0, 4'b0000, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0001, 0, 0, 1, 4'b0001, 1);
        addv(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0001, 1);
        addv(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 1);
        addv(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);
        // Almost-full gating in IDLE only; full also blocks a start.
        addv(1, 1, 4, 4'b0010, 0, 1, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 0, 1, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 0, 1, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 0, 1, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 0, 0, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 0, 0, 1, 4'b0010, 1);
        addv(0, 0, 0, 4'b0010, 0, 1, 1, 4'b0010, 1);
        addv(0, 0, 0, 4'b0010, 0, 1, 1, 4'b0010, 1);
        addv(0, 0, 0, 4'b0010, 0, 1, 1, 4'b0010, 1);
        addv(0, 0, 0, 4'b0010, 0, 1, 0, 4'b0000, 1);
        addv(0, 0, 0, 4'b0010, 0, 1, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 0, 1, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0010, 1, 0, 0, 4'b0000, 0);
        addv(0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0);

        foreach (tv[n]) begin
            if (tv[n].rf) do_reset();
            if (tv[n].pn > 0) push_n(tv[n].psrc, tv[n].pn);
            req = tv[n].req; fifo_full = tv[n].full; fifo_full_n = tv[n].fn;
            #1;
            chk($sformatf("tv%0d_we", n), 32'(fifo_we), 32'(tv[n].we));
            chk($sformatf("tv%0d_gnt", n), 32'(gnt), 32'(tv[n].gnt));
            chk($sformatf("tv%0d_busy", n), 32'(busy), 32'(tv[n].busy));
            chk($sformatf("tv%0d_ack", n), 32'(ack), 32'(tv[n].we ? tv[n].gnt : 4'b0000));
            adv();
        end

        // Round-robin with all requesters active.
        do_reset();
        for (int i = 0; i < 4; i++) nd[i] = data[i];
        for (int b = 0; b < 5; b++) begin
            o = b % 4;
            for (int k = 0; k < 4; k++) begin
                sb.push_back('{o, nd[o]});
                nd[o] = nd[o] + 8'd1;
            end
        end
        req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            oh = 4'b0001 << (b % 4);
            #1;
            chk("rr_idle_gnt", 32'(gnt), 32'd0);
            chk("rr_idle_busy", 32'(busy), 32'd0);
            adv();
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("rr_gnt", 32'(gnt), 32'(oh));
                chk("rr_ack", 32'(ack), 32'(oh));
                adv();
            end
            if (b < 4) begin
                #1;
                chk("rr_gap_we", 32'(fifo_we), 32'd0);
                chk("rr_gap_busy", 32'(busy), 32'd1);
                adv();
            end
        end
        req = '0;
        #1; chk("rr_end_gap", 32'(busy), 32'd1); adv();
        #1; chk("rr_end_idle", 32'(busy), 32'd0); adv();

        // Early release: requester 2 drops after two words, requester 3 is next.
        do_reset();
        push_n(2, 2); push_n(3, 1);
        req = 4'b1100;
        adv();
        for (int k = 0; k < 2; k++) begin
            #1; chk("er_ack2", 32'(ack), 32'h4); adv();
        end
        req = 4'b1000;
        #1; chk("er_drop_we", 32'(fifo_we), 32'd0); chk("er_drop_ack", 32'(ack), 32'd0); adv();
        #1; chk("er_gap_busy", 32'(busy), 32'd1); chk("er_gap_gnt", 32'(gnt), 32'd0); adv();
        #1; chk("er_idle_busy", 32'(busy), 32'd0); adv();
        #1; chk("er_next_gnt", 32'(gnt), 32'h8); chk("er_next_ack", 32'(ack), 32'h8); adv();
        req = '0;
        adv(); adv(); adv();
        #1; chk("er_end_busy", 32'(busy), 32'd0);

        // Full mid-burst: owner 0 cut after one word, pointer still advances to 1.
        do_reset();
        push_n(0, 1); push_n(1, 1);
        req = 4'b0011;
        adv();
        #1; chk("fm_w1_gnt", 32'(gnt), 32'h1); chk("fm_w1_we", 32'(fifo_we), 32'd1); adv();
        fifo_full = 1'b1;
        #1; chk("fm_full_we", 32'(fifo_we), 32'd0); adv();
        fifo_full = 1'b0;
        #1; chk("fm_gap_busy", 32'(busy), 32'd1); chk("fm_gap_we", 32'(fifo_we), 32'd0); adv();
        #1; chk("fm_idle_busy", 32'(busy), 32'd0); adv();
        #1; chk("fm_next_gnt", 32'(gnt), 32'h2); chk("fm_next_ack", 32'(ack), 32'h2); adv();
        req = '0;
        adv(); adv(); adv();
        #1; chk("fm_end_busy", 32'(busy), 32'd0);

        // clr mid-burst, then asynchronous reset mid-burst.
        do_reset();
        push_n(1, 4); push_n(2, 1); push_n(0, 2);
        req = 4'b0110;
        adv();
        for (int k = 0; k < 4; k++) begin
            #1; chk("cr_gnt1", 32'(gnt), 32'h2); adv();
        end
        adv(); adv();
        #1; chk("cr_gnt2", 32'(gnt), 32'h4); chk("cr_we2", 32'(fifo_we), 32'd1); adv();
        clr = 1'b1;
        #1; chk("cr_clr_we", 32'(fifo_we), 32'd0); chk("cr_clr_ack", 32'(ack), 32'd0); adv();
        clr = 1'b0; req = 4'b1111;
        #1; chk("cr_idle_busy", 32'(busy), 32'd0); chk("cr_idle_gnt", 32'(gnt), 32'd0); adv();
        #1; chk("cr_rr0_gnt", 32'(gnt), 32'h1); chk("cr_rr0_we", 32'(fifo_we), 32'd1); adv();
        #1; chk("cr_pre_rst_we", 32'(fifo_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("cr_arst_gnt", 32'(gnt), 32'd0);
        chk("cr_arst_we", 32'(fifo_we), 32'd0);
        chk("cr_arst_busy", 32'(busy), 32'd0);
        chk("cr_arst_ack", 32'(ack), 32'd0);
        adv();
        rst = 1'b1;
        #1; chk("cr_post_busy", 32'(busy), 32'd0); adv();
        #1; chk("cr_post_gnt", 32'(gnt), 32'h1); chk("cr_post_we", 32'(fifo_we), 32'd1); adv();
        req = '0;
        adv(); adv(); adv();
        #1; chk("cr_end_busy", 32'(busy), 32'd0);
        chk("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
